// File: rtl/qam_pkg.sv
// Shared definitions for the 4-QAM loopback chain (modulator and demodulator).
package qam_pkg;

    localparam int SAMPLES_PER_SYM = 128;
    localparam int PHASE_W         = $clog2(SAMPLES_PER_SYM);
    localparam int SAMPLE_W        = 9;
    localparam int CARRIER_AMP     = 100;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_11 = 2'b11;
    localparam logic [1:0] SYM_10 = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/qam_carrier_lut.sv
// Combinational sin/cos carrier ROM, amplitude CARRIER_AMP, one entry per symbol phase.
// Built from a rounded quarter-wave so modulator and demodulator tables stay identical.
module qam_carrier_lut
    import qam_pkg::*;
(
    input  logic        [PHASE_W-1:0]  phase,
    output logic signed [SAMPLE_W-1:0] sin_val,
    output logic signed [SAMPLE_W-1:0] cos_val
);

    // round(100*sin(2*pi*idx/128)) for idx = 0..32
    function automatic logic signed [SAMPLE_W-1:0] quarter_wave(input logic [5:0] idx);
        logic signed [SAMPLE_W-1:0] v;
        case (idx)
            6'd0:  v = 9'sd0;   6'd1:  v = 9'sd5;   6'd2:  v = 9'sd10;  6'd3:  v = 9'sd15;
            6'd4:  v = 9'sd20;  6'd5:  v = 9'sd24;  6'd6:  v = 9'sd29;  6'd7:  v = 9'sd34;
            6'd8:  v = 9'sd38;  6'd9:  v = 9'sd43;  6'd10: v = 9'sd47;  6'd11: v = 9'sd51;
            6'd12: v = 9'sd56;  6'd13: v = 9'sd60;  6'd14: v = 9'sd63;  6'd15: v = 9'sd67;
            6'd16: v = 9'sd71;  6'd17: v = 9'sd74;  6'd18: v = 9'sd77;  6'd19: v = 9'sd80;
            6'd20: v = 9'sd83;  6'd21: v = 9'sd86;  6'd22: v = 9'sd88;  6'd23: v = 9'sd90;
            6'd24: v = 9'sd92;  6'd25: v = 9'sd94;  6'd26: v = 9'sd96;  6'd27: v = 9'sd97;
            6'd28: v = 9'sd98;  6'd29: v = 9'sd99;  6'd30: v = 9'sd100; 6'd31: v = 9'sd100;
            default: v = SAMPLE_W'(CARRIER_AMP);
        endcase
        return v;
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] sine_of(input logic [PHASE_W-1:0] k);
        logic        [5:0]          r;
        logic signed [SAMPLE_W-1:0] mag;
        r = {1'b0, k[4:0]};
        if (k[5]) begin
            mag = quarter_wave(6'd32 - r);
        end else begin
            mag = quarter_wave(r);
        end
        if (k[6]) begin
            return -mag;
        end else begin
            return mag;
        end
    endfunction

    // cosine is the sine table advanced by a quarter period
    always_comb begin
        sin_val = sine_of(phase);
        cos_val = sine_of(phase + 7'd32);
    end

endmodule

// File: rtl/qam_demod.sv
// Coherent 4-QAM demodulator: correlates each 128-sample symbol against the local
// carriers and emits the decided 2-bit symbol with a one-cycle valid pulse.
module qam_demod #(
    parameter int SAMPLES_PER_SYM = 128,
    parameter int SAMPLE_W        = 9,
    parameter int ACC_W           = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_en,
    input  logic                       sym_start,
    output logic        [1:0]          sym_out,
    output logic                       sym_valid,
    output logic signed [ACC_W-1:0]    corr_i,
    output logic signed [ACC_W-1:0]    corr_q,
    output logic                       locked
);
    import qam_pkg::*;

    localparam int                PH_W       = $clog2(SAMPLES_PER_SYM);
    localparam int                PROD_W     = 2 * SAMPLE_W;
    localparam logic [PH_W-1:0]   PHASE_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0]   PHASE_LAST = PH_W'(SAMPLES_PER_SYM - 1);
    localparam logic [ACC_W-1:0]  ACC_ZERO   = {ACC_W{1'b0}};

    state_e                     state_q, state_d;
    logic        [PH_W-1:0]     phase_q, phase_d;
    logic signed [ACC_W-1:0]    acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0]    corr_i_q, corr_i_d, corr_q_q, corr_q_d;
    logic        [1:0]          sym_out_q, sym_out_d;
    logic                       sym_valid_q, sym_valid_d;
    logic                       locked_q, locked_d;

    logic signed [SAMPLE_W-1:0] sin_s, cos_s;
    logic signed [PROD_W-1:0]   prod_i_s, prod_q_s;
    logic signed [ACC_W-1:0]    sum_i_s, sum_q_s;
    logic                       neg_i_s, pos_q_s;

    qam_carrier_lut u_lut (
        .phase   (phase_q),
        .sin_val (sin_s),
        .cos_val (cos_s)
    );

    assign prod_i_s = sample_in * cos_s;
    assign prod_q_s = sample_in * sin_s;
    assign sum_i_s  = acc_i_q + {{(ACC_W-PROD_W){prod_i_s[PROD_W-1]}}, prod_i_s};
    assign sum_q_s  = acc_q_q + {{(ACC_W-PROD_W){prod_q_s[PROD_W-1]}}, prod_q_s};
    assign neg_i_s  = sum_i_s[ACC_W-1];
    assign pos_q_s  = !sum_q_s[ACC_W-1] && (sum_q_s != ACC_ZERO);

    // Next-state, correlator update and symbol decision
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        corr_i_d    = corr_i_q;
        corr_q_d    = corr_q_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = 1'b0;
        if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (sym_start) begin
                        state_d = RUN;
                        phase_d = PHASE_ONE;
                        acc_i_d = ACC_ZERO;
                        acc_q_d = ACC_ZERO;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    // phase 0 carries the modulator's stale latch sample; a strobe elsewhere resyncs
                    if (sym_start || (phase_q == {PH_W{1'b0}})) begin
                        phase_d = PHASE_ONE;
                        acc_i_d = ACC_ZERO;
                        acc_q_d = ACC_ZERO;
                    end else begin
                        phase_d = phase_q + PHASE_ONE;
                        acc_i_d = sum_i_s;
                        acc_q_d = sum_q_s;
                        if (phase_q == PHASE_LAST) begin
                            sym_valid_d = 1'b1;
                            corr_i_d    = sum_i_s;
                            corr_q_d    = sum_q_s;
                            case ({neg_i_s, pos_q_s})
                                2'b00:   sym_out_d = SYM_00;
                                2'b01:   sym_out_d = SYM_01;
                                2'b11:   sym_out_d = SYM_11;
                                default: sym_out_d = SYM_10;
                            endcase
                        end else begin
                            sym_valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            sym_valid_d = 1'b0;
        end
        locked_d = (state_d == RUN);
    end

    // State, correlator and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= {PH_W{1'b0}};
            acc_i_q     <= ACC_ZERO;
            acc_q_q     <= ACC_ZERO;
            corr_i_q    <= ACC_ZERO;
            corr_q_q    <= ACC_ZERO;
            sym_out_q   <= 2'b00;
            sym_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            corr_i_q    <= corr_i_d;
            corr_q_q    <= corr_q_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            locked_q    <= locked_d;
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign corr_i    = corr_i_q;
    assign corr_q    = corr_q_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_qam_demod.sv
// Scoreboard bench for qam_demod: stimulus pushes expected symbols, a negedge monitor
// pops and compares them whenever sym_valid is seen.
module tb_qam_demod;

    logic              clk;
    logic              reset;
    logic signed [8:0] sample_in;
    logic              sample_en;
    logic              sym_start;
    logic        [1:0] sym_out;
    logic              sym_valid;
    logic signed [25:0] corr_i;
    logic signed [25:0] corr_q;
    logic              locked;

    qam_demod dut (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .sample_en (sample_en),
        .sym_start (sym_start),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .corr_i    (corr_i),
        .corr_q    (corr_q),
        .locked    (locked)
    );

    typedef struct {
        logic [1:0] sym;
        longint     ci;
        longint     cq;
        int         cyc;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     tb_sin[128];
    int     tb_cos[128];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int round_amp(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else return -$rtoi(-x + 0.5);
    endfunction

    // mode: 0 -> 00, 1 -> 01, 3 -> 11, 2 -> 10, 4 -> all-zero
    function automatic int sample_of(input int mode, input int k);
        case (mode)
            0:       return tb_cos[k] - tb_sin[k];
            1:       return tb_cos[k] + tb_sin[k];
            3:       return tb_sin[k] - tb_cos[k];
            2:       return -tb_sin[k] - tb_cos[k];
            default: return 0;
        endcase
    endfunction

    task automatic drive(input int s, input logic en, input logic st);
        sample_in = 9'(s);
        sample_en = en;
        sym_start = st;
        @(posedge clk);
        #1;
    endtask

    // One symbol: phase-0 slot (junk sample) then phases 1..last_k
    task automatic run_symbol(input int mode, input logic [1:0] exp_sym, input logic st,
                              input int stall_at, input int last_k);
        longint ei = 0;
        longint eq = 0;
        int     s;
        exp_t   e;
        drive(77, 1'b1, st);
        for (int k = 1; k <= last_k; k++) begin
            if (k == stall_at) begin
                for (int j = 0; j < 5; j++) drive(-123, 1'b0, 1'b1);
            end
            s  = sample_of(mode, k);
            ei += longint'(s * tb_cos[k]);
            eq += longint'(s * tb_sin[k]);
            if (k == 127) begin
                e.sym = exp_sym;
                e.ci  = ei;
                e.cq  = eq;
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
            drive(s, 1'b1, 1'b0);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (sym_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sym_out", longint'(sym_out), longint'(e.sym));
                check("corr_i", longint'(corr_i), e.ci);
                check("corr_q", longint'(corr_q), e.cq);
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        for (int k = 0; k < 128; k++) begin
            tb_sin[k] = round_amp(100.0 * $sin(2.0 * 3.14159265358979 * k / 128.0));
            tb_cos[k] = round_amp(100.0 * $cos(2.0 * 3.14159265358979 * k / 128.0));
        end
        reset = 1'b1; sample_in = 9'sd0; sample_en = 1'b0; sym_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_sym_out", sym_out, 0);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_corr_i", corr_i, 0);
        check("rst_corr_q", corr_q, 0);
        check("rst_locked", locked, 0);
        reset = 1'b0;

        // IDLE ignores samples without a strobe
        for (int j = 0; j < 10; j++) drive(50, 1'b1, 1'b0);
        check("idle_locked", locked, 0);

        // ideal symbol 01
        run_symbol(1, 2'b01, 1'b1, 0, 127);
        check("run_locked", locked, 1);

        // back-to-back 00, 01, 11, 10 with a single strobe, then all-zero
        run_symbol(0, 2'b00, 1'b1, 0, 127);
        run_symbol(1, 2'b01, 1'b0, 0, 127);
        run_symbol(3, 2'b11, 1'b0, 0, 127);
        run_symbol(2, 2'b10, 1'b0, 0, 127);
        run_symbol(4, 2'b00, 1'b0, 0, 127);

        // resync: abandon an 11 at phase 60, then a full 10
        run_symbol(3, 2'b11, 1'b0, 0, 59);
        run_symbol(2, 2'b10, 1'b1, 0, 127);

        // stalled 01
        run_symbol(1, 2'b01, 1'b0, 50, 127);

        // reset at phase 40 of an 11
        run_symbol(3, 2'b11, 1'b0, 0, 39);
        reset = 1'b1;
        #1;
        check("mid_rst_sym_out", sym_out, 0);
        check("mid_rst_sym_valid", sym_valid, 0);
        check("mid_rst_corr_i", corr_i, 0);
        check("mid_rst_corr_q", corr_q, 0);
        check("mid_rst_locked", locked, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int j = 0; j < 200; j++) drive(90, 1'b1, 1'b0);
        check("post_rst_locked", locked, 0);
        run_symbol(3, 2'b11, 1'b1, 0, 127);

        for (int j = 0; j < 4; j++) drive(0, 1'b0, 1'b0);
        check("pending_pulses", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
